fwd_sel_pipe: RTL and testbench

//  Parametrised operand-forwarding selector for the five-stage pipeline: tracks in-flight

---
 rtl/fwd_sel_pipe_pkg.sv | 24 ++
 rtl/fwd_port_sel.sv | 53 +++++
 rtl/fwd_sel_pipe.sv | 95 +++++++++
 tb/tb_fwd_sel_pipe.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_sel_pipe_pkg.sv
// Shared constants for the operand-forwarding selector.
// Stage indices, Tnew/Tuse codes and default entry layout.
package fwd_sel_pipe_pkg;

    localparam int STG_E = 0;
    localparam int STG_M = 1;
    localparam int STG_W = 2;

    localparam int FWD_AW = 5;
    localparam int FWD_TW = 2;

    localparam logic [FWD_TW-1:0] T_ALU    = 2'd1;
    localparam logic [FWD_TW-1:0] T_LOAD   = 2'd2;
    localparam logic [FWD_TW-1:0] TUSE_BR  = 2'd0;
    localparam logic [FWD_TW-1:0] TUSE_ALU = 2'd1;
    localparam logic [FWD_TW-1:0] TUSE_ST  = 2'd2;

    typedef struct packed {
        logic              v;
        logic [FWD_AW-1:0] a3;
        logic [FWD_TW-1:0] tnew;
    } fwd_ent_t;

endpackage

// File: rtl/fwd_port_sel.sv
// Single read-port forwarding select: youngest match, mux, hazard.
// Ports: i_v/i_a3/i_tnew entries, i_addr/i_tuse/i_rf port, i_stg results; o_op, o_haz.
module fwd_port_sel
    import fwd_sel_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 3,
    parameter int TW    = 2
) (
    input  logic [DEPTH-1:0]       i_v,
    input  logic [DEPTH*AW-1:0]    i_a3,
    input  logic [DEPTH*TW-1:0]    i_tnew,
    input  logic [AW-1:0]          i_addr,
    input  logic [TW-1:0]          i_tuse,
    input  logic [WIDTH-1:0]       i_rf,
    input  logic [DEPTH*WIDTH-1:0] i_stg,
    output logic [WIDTH-1:0]       o_op,
    output logic                   o_haz
);

    logic             w_hit;
    logic [TW-1:0]    w_tnew;
    logic [WIDTH-1:0] w_data;

    // Scan oldest to youngest so the youngest match overwrites;
    // older entries behind it are thereby ignored.
    always_comb begin
        w_hit  = 1'b0;
        w_tnew = '0;
        w_data = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (i_v[k] && (i_a3[k*AW +: AW] == i_addr)
                && (i_addr != '0)) begin
                w_hit  = 1'b1;
                w_tnew = i_tnew[k*TW +: TW];
                w_data = i_stg[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        o_op  = i_rf;
        o_haz = 1'b0;
        if (w_hit) begin
            if (w_tnew == '0) begin
                o_op = w_data;
            end
            o_haz = (w_tnew > i_tuse);
        end
    end

endmodule

// File: rtl/fwd_sel_pipe.sv
// Operand forwarding selector: tracks E/M/W writes, picks operands, stalls.
// Optional FWD_STALL_CNT_EN adds a 32-bit stall-cycle counter on stall_cnt.
module fwd_sel_pipe
    import fwd_sel_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int NRD   = 2,
    parameter int DEPTH = 3,
    parameter int TW    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   iss_valid,
    input  logic [AW-1:0]          iss_a3,
    input  logic [TW-1:0]          iss_tnew,
    input  logic                   flush,
    input  logic [NRD*AW-1:0]      rd_addr,
    input  logic [NRD*TW-1:0]      rd_tuse,
    input  logic [NRD*WIDTH-1:0]   rf_data,
    input  logic [DEPTH*WIDTH-1:0] stg_data,
    output logic [NRD*WIDTH-1:0]   op_data,
    output logic                   stall_req,
    output logic [31:0]            stall_cnt
);

    logic [DEPTH-1:0]    r_v;
    logic [DEPTH*AW-1:0] r_a3;
    logic [DEPTH*TW-1:0] r_tnew;
    logic [NRD-1:0]      w_haz;

    function automatic logic [TW-1:0] f_dec(
        input logic [TW-1:0] t
    );
        return (t == '0) ? t : t - TW'(1);
    endfunction

    // Stalled issues enter E as a bubble; the shift never freezes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v    <= '0;
            r_a3   <= '0;
            r_tnew <= '0;
        end else begin
            r_v[STG_E] <= iss_valid & ~stall_req
                        & (iss_a3 != '0) & ~flush;
            r_a3[STG_E*AW +: AW]   <= iss_a3;
            r_tnew[STG_E*TW +: TW] <= iss_tnew;
            for (int k = 1; k < DEPTH; k++) begin
                r_v[k] <= r_v[k-1] & ~flush;
                r_a3[k*AW +: AW] <= r_a3[(k-1)*AW +: AW];
                r_tnew[k*TW +: TW] <=
                    f_dec(r_tnew[(k-1)*TW +: TW]);
            end
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_port
        fwd_port_sel #(
            .WIDTH (WIDTH),
            .AW    (AW),
            .DEPTH (DEPTH),
            .TW    (TW)
        ) u_sel (
            .i_v    (r_v),
            .i_a3   (r_a3),
            .i_tnew (r_tnew),
            .i_addr (rd_addr[g*AW +: AW]),
            .i_tuse (rd_tuse[g*TW +: TW]),
            .i_rf   (rf_data[g*WIDTH +: WIDTH]),
            .i_stg  (stg_data),
            .o_op   (op_data[g*WIDTH +: WIDTH]),
            .o_haz  (w_haz[g])
        );
    end

    assign stall_req = |w_haz;

`ifdef FWD_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (stall_req) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fwd_sel_pipe.sv
// Scoreboard bench for fwd_sel_pipe against an instruction-list model.
// Directed hazard scenarios followed by randomized traffic.
module tb_fwd_sel_pipe;

    localparam int WIDTH = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int DEPTH = 3;
    localparam int TW    = 2;

    logic                   clk;
    logic                   reset;
    logic                   iss_valid;
    logic [AW-1:0]          iss_a3;
    logic [TW-1:0]          iss_tnew;
    logic                   flush;
    logic [NRD*AW-1:0]      rd_addr;
    logic [NRD*TW-1:0]      rd_tuse;
    logic [NRD*WIDTH-1:0]   rf_data;
    logic [DEPTH*WIDTH-1:0] stg_data;
    logic [NRD*WIDTH-1:0]   op_data;
    logic                   stall_req;
    logic [31:0]            stall_cnt;

    fwd_sel_pipe #(
        .WIDTH (WIDTH),
        .AW    (AW),
        .NRD   (NRD),
        .DEPTH (DEPTH),
        .TW    (TW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .iss_valid (iss_valid),
        .iss_a3    (iss_a3),
        .iss_tnew  (iss_tnew),
        .flush     (flush),
        .rd_addr   (rd_addr),
        .rd_tuse   (rd_tuse),
        .rf_data   (rf_data),
        .stg_data  (stg_data),
        .op_data   (op_data),
        .stall_req (stall_req),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int issue;
        int a3;
        int tnew;
    } rec_t;

    typedef struct {
        logic [WIDTH-1:0] op0;
        logic [WIDTH-1:0] op1;
        logic             st;
        logic [31:0]      cnt;
    } exp_t;

    rec_t recs[$];
    exp_t q[$];
    int   cyc;
    int   m_cnt;
    logic p_valid;
    logic p_stall;
    logic p_flush;
    int   p_a3;
    int   p_tnew;
    int   checks;
    int   errors;

    // Each issued instruction reaches stage (cyc-issue-1); its
    // remaining latency is its Tnew minus that stage, floored at 0.
    function automatic void model_eval(output exp_t e);
        e.op0 = '0;
        e.op1 = '0;
        e.st  = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            int addr, tuse, best, bst, bt;
            logic [WIDTH-1:0] d;
            addr = int'(rd_addr[i*AW +: AW]);
            tuse = int'(rd_tuse[i*TW +: TW]);
            d    = rf_data[i*WIDTH +: WIDTH];
            best = -1;
            bst  = 0;
            bt   = 0;
            foreach (recs[j]) begin
                int st;
                st = cyc - recs[j].issue - 1;
                if (st >= 0 && st < DEPTH && addr != 0
                    && recs[j].a3 == addr
                    && recs[j].issue > best) begin
                    best = recs[j].issue;
                    bst  = st;
                    bt   = recs[j].tnew - st;
                    if (bt < 0) bt = 0;
                end
            end
            if (best >= 0) begin
                if (bt == 0) d = stg_data[bst*WIDTH +: WIDTH];
                if (bt > tuse) e.st = 1'b1;
            end
            if (i == 0) e.op0 = d;
            else        e.op1 = d;
        end
`ifdef FWD_STALL_CNT_EN
        e.cnt = 32'(m_cnt);
`else
        e.cnt = 32'h0;
`endif
    endfunction

    task automatic model_edge();
        if (!reset) begin
            recs.delete();
            m_cnt = 0;
        end else begin
            if (p_stall) m_cnt++;
            if (p_flush) begin
                recs.delete();
            end else if (p_valid && !p_stall && p_a3 != 0) begin
                recs.push_back('{cyc, p_a3, p_tnew});
            end
        end
        cyc++;
        while (recs.size() > 0
               && cyc - recs[0].issue - 1 >= DEPTH)
            void'(recs.pop_front());
    endtask

    task automatic step(
        input logic rst_v, input logic v,
        input int a3, input int tn, input logic fl,
        input int ad0, input int tu0,
        input int ad1, input int tu1,
        input logic mid_rst
    );
        exp_t e;
        @(posedge clk);
        model_edge();
        #1;
        reset     = rst_v;
        iss_valid = v;
        iss_a3    = AW'(a3);
        iss_tnew  = TW'(tn);
        flush     = fl;
        rd_addr   = {AW'(ad1), AW'(ad0)};
        rd_tuse   = {TW'(tu1), TW'(tu0)};
        rf_data   = {(ad1 == 0) ? 32'h0 : $urandom(),
                     (ad0 == 0) ? 32'h0 : $urandom()};
        stg_data  = {$urandom(), $urandom(), $urandom()};
        #1;
        model_eval(e);
        if (mid_rst) begin
            checks++;
            if (stall_req !== e.st) begin
                errors++;
                $display("FAIL pre_reset_stall got=%0b exp=%0b",
                         stall_req, e.st);
            end
            reset = 1'b0;
            #1;
            recs.delete();
            m_cnt = 0;
            model_eval(e);
        end
        q.push_back(e);
        p_valid = v;
        p_a3    = a3;
        p_tnew  = tn;
        p_flush = fl;
        p_stall = e.st;
    endtask

    task automatic cmp(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h",
                     nm, cyc, got, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("op0", op_data[0 +: WIDTH], e.op0);
                cmp("op1", op_data[WIDTH +: WIDTH], e.op1);
                cmp("stall", {31'h0, stall_req}, {31'h0, e.st});
                cmp("stall_cnt", stall_cnt, e.cnt);
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        m_cnt     = 0;
        p_valid   = 1'b0;
        p_stall   = 1'b0;
        p_flush   = 1'b0;
        p_a3      = 0;
        p_tnew    = 0;
        reset     = 1'b0;
        iss_valid = 1'b0;
        iss_a3    = '0;
        iss_tnew  = '0;
        flush     = 1'b0;
        rd_addr   = '0;
        rd_tuse   = '0;
        rf_data   = '0;
        stg_data  = '0;

        step(0, 0, 0, 0, 0, 3, 0, 5, 0, 0);
        step(1, 0, 0, 0, 0, 3, 0, 5, 0, 0);

        step(1, 1, 3, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);

        step(1, 1, 8, 2, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            step(1, 0, 0, 0, 0, 0, 0, 8, 0, 0);

        step(1, 1, 4, 2, 0, 0, 0, 0, 0, 0);
        step(1, 1, 4, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 0, 0, 4, 0, 4, 1, 0);

        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 6, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 7, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 9, 2, 0, 6, 3, 7, 3, 0);
        step(1, 0, 0, 0, 1, 9, 0, 7, 0, 0);
        step(1, 0, 0, 0, 0, 9, 0, 7, 0, 0);
        step(1, 0, 0, 0, 0, 6, 0, 9, 0, 0);

        step(1, 1, 8, 2, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 8, 0, 1);
        step(1, 0, 0, 0, 0, 8, 0, 8, 0, 0);

        for (int n = 0; n < 2000; n++) begin
            step(1,
                 ($urandom_range(0, 9) < 7),
                 $urandom_range(0, 7),
                 $urandom_range(0, 3),
                 ($urandom_range(0, 19) == 0),
                 $urandom_range(0, 7),
                 $urandom_range(0, 3),
                 $urandom_range(0, 7),
                 $urandom_range(0, 3),
                 ($urandom_range(0, 99) == 0));
        end
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int t = 0; t < 5 && q.size() > 0; t++)
            @(negedge clk);
        #1;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout left=%0d exp=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
